// File: rtl/piezo_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : piezo_arbiter
//  Description : Shares one piezo buzzer among three tone generators
//                (bit 0 shot, bit 1 hit, bit 2 win). One-cycle request
//                pulses are latched in a pending mask. One generator is
//                granted at a time by fixed priority (win > hit > shot).
//                A silent gap is inserted after every sound. The granted
//                generator's tone is registered onto the buzzer output.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    HOLD_CYCLES  minimum grant length before a preemption may take effect
//    GAP_CYCLES   silent cycles inserted after every sound
//    MAX_CYCLES   play timeout used when the generator never reports done
//  Ports
//    clk           system clock
//    rst           asynchronous active-high reset
//    req_i[2:0]    one-cycle sound request pulses
//    src_piezo_i   tone outputs of the three generators
//    done_i[2:0]   generator end-of-sound; only the granted bit is used
//    en_o[2:0]     one-hot generator enable (grant), registered
//    busy_o        high while playing or in the silent gap, registered
//    piezo_out_o   buzzer drive, registered (one cycle behind the tone)
//  Build option
//    PIEZO_PREEMPT_EN  when defined, a strictly higher pending request
//                      aborts the current sound once the hold time is met.
// ============================================================================
module piezo_arbiter #(
    parameter int HOLD_CYCLES = 1000,
    parameter int GAP_CYCLES  = 500,
    parameter int MAX_CYCLES  = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req_i,
    input  logic [2:0] src_piezo_i,
    input  logic [2:0] done_i,
    output logic [2:0] en_o,
    output logic       busy_o,
    output logic       piezo_out_o
);

    // ------------------------------------------------------------------------
    // Counter sizing: one shared counter serves hold, gap and timeout.
    // ------------------------------------------------------------------------
    localparam int c_BIG_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_BIG    = (c_BIG_HG > MAX_CYCLES) ? c_BIG_HG : MAX_CYCLES;
    localparam int c_CNT_W  = $clog2(c_BIG) + 1;

    localparam logic [c_CNT_W-1:0] c_MAX     = c_CNT_W'(MAX_CYCLES);
    localparam logic [c_CNT_W-1:0] c_MAX_M1  = c_CNT_W'(MAX_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_M1  = c_CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [2:0]           pend_q,  pend_d;
    logic [2:0]           en_q,    en_d;
    logic [c_CNT_W-1:0]   cnt_q,   cnt_d;
    logic [1:0]           gsel_q,  gsel_d;   // index of the granted generator
    logic                 busy_q,  busy_d;
    logic                 piezo_q, piezo_d;

    logic [1:0]           w_sel;             // highest pending request
    logic [2:0]           w_sel_onehot;
    logic [2:0]           w_pend_clr;
    logic                 w_done;
    logic                 w_timeout;
    logic                 w_preempt;

    // ------------------------------------------------------------------------
    // Fixed-priority selection: win > hit > shot.
    // ------------------------------------------------------------------------
    always_comb begin
        w_sel = 2'd0;
        if (pend_q[2]) begin
            w_sel = 2'd2;
        end else if (pend_q[1]) begin
            w_sel = 2'd1;
        end else begin
            w_sel = 2'd0;
        end
    end

    assign w_sel_onehot = 3'b001 << w_sel;

    // Only the granted generator's completion is observed.
    assign w_done    = done_i[gsel_q];
    assign w_timeout = (cnt_q == c_MAX_M1);

`ifdef PIEZO_PREEMPT_EN
    localparam logic [c_CNT_W-1:0] c_HOLD_M1 = c_CNT_W'(HOLD_CYCLES - 1);

    logic w_higher;

    // A pending bit strictly above the current grant.
    always_comb begin
        w_higher = 1'b0;
        case (gsel_q)
            2'd0:    w_higher = pend_q[2] | pend_q[1];
            2'd1:    w_higher = pend_q[2];
            default: w_higher = 1'b0;
        endcase
    end

    // The aborted sound is not requeued; its pend bit was cleared at grant.
    assign w_preempt = w_higher && (cnt_q >= c_HOLD_M1);
`else
    assign w_preempt = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        cnt_d      = cnt_q;
        gsel_d     = gsel_q;
        w_pend_clr = 3'b000;

        case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    state_d    = S_PLAY;
                    en_d       = w_sel_onehot;
                    gsel_d     = w_sel;
                    w_pend_clr = w_sel_onehot;
                    cnt_d      = '0;
                end
            end

            S_PLAY: begin
                if (cnt_q != c_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (w_done || w_timeout || w_preempt) begin
                    state_d = S_GAP;
                    en_d    = 3'b000;
                    cnt_d   = '0;
                end
            end

            S_GAP: begin
                if (cnt_q == c_GAP_M1) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                en_d    = 3'b000;
                cnt_d   = '0;
            end
        endcase
    end

    // A request on the grant edge wins over the clear so it plays again.
    assign pend_d  = (pend_q & ~w_pend_clr) | req_i;
    assign busy_d  = (state_d != S_IDLE);
    // Sampled from the current state, so the tone appears one edge after
    // the enable and stops one edge after the enable drops.
    assign piezo_d = (state_q == S_PLAY) ? src_piezo_i[gsel_q] : 1'b0;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pend_q  <= 3'b000;
            en_q    <= 3'b000;
            cnt_q   <= '0;
            gsel_q  <= 2'd0;
            busy_q  <= 1'b0;
            piezo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            gsel_q  <= gsel_d;
            busy_q  <= busy_d;
            piezo_q <= piezo_d;
        end
    end

    assign en_o        = en_q;
    assign busy_o      = busy_q;
    assign piezo_out_o = piezo_q;

endmodule
`default_nettype wire

// File: tb/tb_piezo_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piezo_arbiter
//  Description : Directed self-checking bench for piezo_arbiter with a grant
//                scoreboard. Expected grants are queued when requests are
//                driven and compared when the enable rises.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_piezo_arbiter;

    localparam int c_HOLD = 4;
    localparam int c_GAP  = 3;
    localparam int c_MAX  = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req_i;
    logic [2:0] src_piezo_i = 3'b000;
    logic [2:0] done_i;
    logic [2:0] en_o;
    logic       busy_o;
    logic       piezo_out_o;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [2:0] sb_q[$];
    logic [2:0] prev_en = 3'b000;

    piezo_arbiter #(
        .HOLD_CYCLES (c_HOLD),
        .GAP_CYCLES  (c_GAP),
        .MAX_CYCLES  (c_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .src_piezo_i (src_piezo_i),
        .done_i      (done_i),
        .en_o        (en_o),
        .busy_o      (busy_o),
        .piezo_out_o (piezo_out_o)
    );

    always #5 clk = ~clk;

    // Tone sources change away from the active edge.
    always @(negedge clk) src_piezo_i <= 3'($urandom);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts edges until a grant appears (bounded).
    task automatic wait_grant(output int n);
        n = 0;
        while (en_o == 3'b000 && n < 100) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 200) begin
            tick(1);
            n++;
        end
        chk("idle_reached", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic pulse_done(input logic [2:0] d);
        done_i = d;
        tick(1);
        done_i = 3'b000;
    endtask

    // Scoreboard check on every rising grant.
    always @(negedge clk) begin
        if (rst) begin
            prev_en <= 3'b000;
        end else begin
            if (en_o != 3'b000 && prev_en == 3'b000) begin
                if (sb_q.size() == 0) begin
                    chk("grant_unexpected", {29'd0, en_o}, 32'd0);
                end else begin
                    logic [2:0] exp_en;
                    exp_en = sb_q.pop_front();
                    chk("grant_order", {29'd0, en_o}, {29'd0, exp_en});
                end
            end
            prev_en <= en_o;
        end
    end

    initial begin
        int n;
        rst    = 1'b1;
        req_i  = 3'b000;
        done_i = 3'b000;
        tick(3);
        rst = 1'b0;

        // ---- reset state
        chk("rst_en",    {29'd0, en_o},          32'd0);
        chk("rst_busy",  {31'd0, busy_o},        32'd0);
        chk("rst_piezo", {31'd0, piezo_out_o},   32'd0);
        chk("rst_pend",  {29'd0, dut.pend_q},    32'd0);
        tick(5);

        // ---- single hit request: latency and tone mirroring
        req_i = 3'b010;
        sb_q.push_back(3'b010);
        tick(1);
        req_i = 3'b000;
        chk("lat_pend", {29'd0, dut.pend_q}, 32'h2);
        chk("lat_en0",  {29'd0, en_o},       32'd0);
        tick(1);
        chk("lat_en",   {29'd0, en_o},       32'h2);
        chk("lat_busy", {31'd0, busy_o},     32'd1);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("piezo_mirror", {31'd0, piezo_out_o}, {31'd0, src_piezo_i[1]});
        end

        // ---- done ends the sound, gap of GAP cycles
        pulse_done(3'b010);
        chk("done_en",   {29'd0, en_o},   32'd0);
        chk("gap_busy0", {31'd0, busy_o}, 32'd1);
        tick(1);
        chk("gap_busy1",  {31'd0, busy_o},      32'd1);
        chk("gap_piezo1", {31'd0, piezo_out_o}, 32'd0);
        tick(1);
        chk("gap_busy2",  {31'd0, busy_o},      32'd1);
        chk("gap_piezo2", {31'd0, piezo_out_o}, 32'd0);
        tick(1);
        chk("gap_end_busy", {31'd0, busy_o},     32'd0);
        chk("gap_end_pend", {29'd0, dut.pend_q}, 32'd0);
        tick(3);

        // ---- simultaneous requests served in priority order
        req_i = 3'b111;
        sb_q.push_back(3'b100);
        sb_q.push_back(3'b010);
        sb_q.push_back(3'b001);
        tick(1);
        req_i = 3'b000;
        wait_grant(n);
        chk("multi_win_grant", {29'd0, en_o}, 32'h4);
        tick(1);
        pulse_done(3'b011);
        chk("ignore_other_done", {29'd0, en_o}, 32'h4);
        pulse_done(3'b100);
        chk("win_done_en", {29'd0, en_o}, 32'd0);
        wait_grant(n);
        chk("gap_len_1", n, c_GAP + 1);
        chk("multi_hit_grant", {29'd0, en_o}, 32'h2);
        tick(2);
        pulse_done(3'b010);
        chk("hit_done_en", {29'd0, en_o}, 32'd0);
        wait_grant(n);
        chk("gap_len_2", n, c_GAP + 1);
        chk("multi_shot_grant", {29'd0, en_o}, 32'h1);
        tick(2);
        pulse_done(3'b001);
        wait_idle();
        tick(2);

        // ---- timeout with done held low
        req_i = 3'b001;
        sb_q.push_back(3'b001);
        tick(1);
        req_i = 3'b000;
        tick(1);
        chk("to_grant", {29'd0, en_o}, 32'h1);
        n = 0;
        while (en_o != 3'b000 && n < 60) begin
            tick(1);
            n++;
        end
        chk("timeout_len", n, c_MAX);
        tick(1);
        chk("to_gap_piezo1", {31'd0, piezo_out_o}, 32'd0);
        chk("to_gap_busy",   {31'd0, busy_o},      32'd1);
        tick(1);
        chk("to_gap_piezo2", {31'd0, piezo_out_o}, 32'd0);
        wait_idle();
        tick(2);

        // ---- higher request while shot plays (request sampled at cnt=1)
        req_i = 3'b001;
        sb_q.push_back(3'b001);
        tick(1);
        req_i = 3'b000;
        tick(1);
        chk("pre_shot_grant", {29'd0, en_o}, 32'h1);
        tick(1);
        req_i = 3'b100;
        sb_q.push_back(3'b100);
        tick(1);
        req_i = 3'b000;
        chk("pre_pend", {29'd0, dut.pend_q}, 32'h4);
`ifdef PIEZO_PREEMPT_EN
        tick(1);
        chk("pre_hold_en", {29'd0, en_o}, 32'h1);
        tick(1);
        chk("pre_abort_en", {29'd0, en_o}, 32'd0);
        wait_grant(n);
        chk("pre_gap_len", n, c_GAP + 1);
        chk("pre_win_grant", {29'd0, en_o}, 32'h4);
        tick(1);
        pulse_done(3'b100);
        wait_idle();
        tick(10);
        chk("pre_no_replay_en",   {29'd0, en_o},       32'd0);
        chk("pre_no_replay_pend", {29'd0, dut.pend_q}, 32'd0);
`else
        tick(5);
        chk("nopre_shot_holds", {29'd0, en_o}, 32'h1);
        pulse_done(3'b001);
        chk("nopre_shot_done", {29'd0, en_o}, 32'd0);
        wait_grant(n);
        chk("nopre_gap_len", n, c_GAP + 1);
        chk("nopre_win_grant", {29'd0, en_o}, 32'h4);
        tick(1);
        pulse_done(3'b100);
        wait_idle();
`endif
        tick(2);

        // ---- asynchronous reset mid-play with pend = 101
        req_i = 3'b010;
        sb_q.push_back(3'b010);
        tick(1);
        req_i = 3'b000;
        tick(1);
        chk("rp_grant", {29'd0, en_o}, 32'h2);
        req_i = 3'b101;
        tick(1);
        req_i = 3'b000;
        chk("rp_pend", {29'd0, dut.pend_q}, 32'h5);
        #2;
        rst = 1'b1;
        #1;
        chk("rp_en",    {29'd0, en_o},        32'd0);
        chk("rp_busy",  {31'd0, busy_o},      32'd0);
        chk("rp_piezo", {31'd0, piezo_out_o}, 32'd0);
        chk("rp_pend0", {29'd0, dut.pend_q},  32'd0);
        tick(2);
        rst = 1'b0;
        tick(10);
        chk("post_rst_en",   {29'd0, en_o},       32'd0);
        chk("post_rst_busy", {31'd0, busy_o},     32'd0);
        chk("post_rst_pend", {29'd0, dut.pend_q}, 32'd0);

        chk("sb_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
